spi_target: RTL and testbench
=============================

# spi_target

SPI responder (mode 0, MSB first) that lets an external SPI host exchange bytes with the CPU. It sits on the CPU bus beside the flash SPI initiator and the UART, as the other end of the same serial protocol. It oversamples SCK/SS/MOSI in the system clock domain, delivers received bytes to a read register, and shifts out a CPU-loaded reply byte.

## Interface
- IDLE_BYTE, 8'hFF, byte shifted out when the CPU has not loaded a reply
- FIFO_DEPTH, 16, RX FIFO depth (power of two); used only when SPI_TARGET_FIFO_EN is defined
- input_clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- spi_sck  in  1  host SPI clock, idle low
- spi_ss  in  1  host chip select, active low
- spi_mosi  in  1  host data out
- spi_miso  out  1  responder data out
- spi_miso_oe  out  1  MISO drive enable (high while selected)
- sys_we  in  1  write strobe: load reply byte from sys_wdata
- sys_wdata  in  8  reply byte
- sys_rd  in  1  read strobe: pop the current RX byte
- sys_clr  in  1  clear rx_overrun
- sys_rdata  out  8  current RX byte (head of queue)
- rx_valid  out  1  sys_rdata holds an unread byte
- rx_overrun  out  1  sticky: a completed byte was dropped
- tx_empty  out  1  reply register free for a new byte
- frame_active  out  1  synchronized SS asserted
- irq  out  1  rx_valid | frame_end_flag (flag cleared by sys_clr)

## Operation
- spi_sck, spi_ss, spi_mosi pass through 2-FF synchronizers; a third register gives edge detect on SCK and SS.
- States: IDLE (SS high) and ACTIVE. IDLE->ACTIVE on synchronized SS fall; ACTIVE->IDLE on SS rise, from any bit position.
- On entry to ACTIVE: bit_cnt=0, tx_shift loaded from the reply register if it is full, otherwise from IDLE_BYTE. The reply register is marked empty when loaded. spi_miso=tx_shift[7].
- SCK rise: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++ (3-bit, wraps 7->0). On wrap, the byte is complete and is pushed to RX.
- SCK fall: if the preceding rise completed a byte, reload tx_shift (same rule as entry). Otherwise shift tx_shift left by 1, filling with 1.
- SS rise mid-byte: the partial byte is discarded, bit_cnt=0, frame_end_flag=1, spi_miso_oe=0.
- RX push when the queue is full: the byte is dropped, rx_overrun=1, and the queue is unchanged. A push and sys_rd in the same cycle are both honoured, with no overrun.
- sys_we while the reply register is full overwrites it. If sys_we coincides with a reload, the reload takes the old value and the written byte stays pending (tx_empty=0).
- sys_rd with rx_valid=0 is ignored.
- Reset values: spi_miso=1, spi_miso_oe=0, sys_rdata=0, rx_valid=0, rx_overrun=0, tx_empty=1, frame_active=0, irq=0, bit_cnt=0, reply register empty.

## Timing
- Input synchronizer latency is 2 input_clk cycles; edge detect adds 1.
- rx_valid rises 4 input_clk edges after the first edge that samples the 8th SCK high. sys_rdata is valid in the same cycle.
- spi_miso updates 3 input_clk edges after SCK fall is first sampled. SCK half-period must be at least 4 input_clk cycles (SCK ≤ input_clk/8, 1.5 MHz at 12 MHz).
- SS fall to first host SCK rise: ≥4 input_clk cycles.
- sys_rd pops on the clock edge; the next byte, if any, appears on sys_rdata the following cycle.

## Configuration
- SPI_TARGET_FIFO_EN defined: RX is a FIFO_DEPTH-entry FIFO, and sys_rdata shows the head entry.
- SPI_TARGET_FIFO_EN undefined: RX is a single holding register; "full" means rx_valid=1.
- TX is a single reply register in both builds.

## Structure
- Shared package: SPI mode constants, IDLE_BYTE default, state encoding (IDLE/ACTIVE).
- Sub-module sync_fifo (8-bit data, parameter depth, push/pop/full/empty, first-word-fall-through), instantiated only under SPI_TARGET_FIFO_EN.
- Synchronizers and the shifter stay inline.

## Test plan
- Host sends 8'hA5 with no reply loaded -> rx_valid=1, sys_rdata=8'hA5, host receives 8'hFF.
- CPU writes 8'h3C, then host sends 8'h00 -> host receives 8'h3C, tx_empty returns to 1 at SS fall.
- Host sends 3 bytes without sys_rd: non-FIFO build -> sys_rdata=first byte, rx_overrun=1; FIFO build -> three pops return bytes in order, rx_overrun=0.
- SS deasserted after 5 bits -> no push, frame_end_flag/irq=1, next frame starts at bit 0 and receives 8'h81 correctly.
- sys_rd coinciding with byte completion (non-FIFO) -> new byte shown, rx_valid stays 1, rx_overrun=0.
- reset asserted mid-byte -> all outputs at reset values next edge; a following frame of 8'h5A is received intact.

Source files
------------

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: constants and types shared by the SPI responder files.
//   SPI_CPOL      : clock idle level for mode 0, used as the SCK synchronizer reset value
//   IDLE_BYTE_DEF : default byte shifted out when no reply is pending
//   state_t       : frame state (IDLE while SS is high, ACTIVE while selected)
package spi_target_pkg;
  localparam logic       SPI_CPOL      = 1'b0;
  localparam logic       SPI_CPHA      = 1'b0;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/spi_target_sync_fifo.sv
// sync_fifo: 8-bit first-word-fall-through FIFO. The head entry is always
// visible on dout_o, and dout_o reads 0 while the FIFO is empty.
//   input_clk, reset : clock, asynchronous active-high reset
//   push_i, din_i    : write request and data. A push while full is accepted
//                      only when a pop in the same cycle frees a slot.
//   pop_i            : remove the head entry. Ignored while empty.
//   dout_o           : head entry
//   full_o, empty_o  : occupancy flags
// DEPTH must be a power of two.
module sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       input_clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_ff @(posedge input_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/spi_target.sv
// spi_target: SPI responder (mode 0, MSB first) bridging an external SPI
// host to the CPU bus. SCK/SS/MOSI are oversampled in the input_clk domain.
// Optional build macro: SPI_TARGET_FIFO_EN. When it is defined, RX is a
// FIFO_DEPTH-entry FIFO. When it is undefined, RX is a single holding
// register.
//   spi_sck/spi_ss/spi_mosi : host SPI inputs (SCK idles low, SS active low)
//   spi_miso, spi_miso_oe   : responder data out and its drive enable
//   sys_we, sys_wdata       : load the reply byte
//   sys_rd                  : pop the RX head
//   sys_clr                 : clear rx_overrun and the frame-end flag
//   sys_rdata, rx_valid     : RX head and its valid flag
//   rx_overrun              : sticky, set when a completed byte was dropped
//   tx_empty                : reply register is free
//   frame_active            : synchronized SS is asserted
//   irq                     : rx_valid | frame-end flag
module spi_target
  import spi_target_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEF,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic       input_clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       sys_we,
  input  logic [7:0] sys_wdata,
  input  logic       sys_rd,
  input  logic       sys_clr,
  output logic [7:0] sys_rdata,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       tx_empty,
  output logic       frame_active,
  output logic       irq
);
  // Bits [1:0] of each register form the 2-FF synchronizer. Bit 2 is the
  // previous synchronized value, used for edge detection.
  logic [2:0] sck_q, ss_q, mosi_q;
  logic       sck_rise_q, sck_fall_q, ss_fall_q, ss_rise_q;

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sck_q      <= {3{SPI_CPOL}};
      ss_q       <= 3'b111;
      mosi_q     <= 3'b000;
      sck_rise_q <= 1'b0;
      sck_fall_q <= 1'b0;
      ss_fall_q  <= 1'b0;
      ss_rise_q  <= 1'b0;
    end else begin
      sck_q      <= {sck_q[1:0], spi_sck};
      ss_q       <= {ss_q[1:0], spi_ss};
      mosi_q     <= {mosi_q[1:0], spi_mosi};
      sck_rise_q <= sck_q[1] & ~sck_q[2];
      sck_fall_q <= ~sck_q[1] & sck_q[2];
      ss_fall_q  <= ~ss_q[1] & ss_q[2];
      ss_rise_q  <= ss_q[1] & ~ss_q[2];
    end
  end

  // mosi_q[2] lines up with the sample that first showed SCK high.
  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_shift_q, tx_shift_q, push_data_q, reply_q;
  logic       byte_done_q, push_q, miso_oe_q, frame_end_q, reply_full_q;
  logic       tx_load;
  logic [7:0] tx_next, rx_next;

  assign tx_next = reply_full_q ? reply_q : IDLE_BYTE;
  assign rx_next = {rx_shift_q[6:0], mosi_q[2]};
  assign tx_load = ((state_q == ST_IDLE) && ss_fall_q) ||
                   ((state_q == ST_ACTIVE) && !ss_rise_q && sck_fall_q && byte_done_q);

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 8'h00;
      tx_shift_q   <= 8'hFF;
      byte_done_q  <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= 8'h00;
      miso_oe_q    <= 1'b0;
      frame_end_q  <= 1'b0;
      reply_q      <= 8'h00;
      reply_full_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (sys_clr) frame_end_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ss_fall_q) begin
            state_q     <= ST_ACTIVE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            miso_oe_q   <= 1'b1;
            tx_shift_q  <= tx_next;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise_q) begin
            // Any partial byte is abandoned. The next frame starts at bit 0.
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            miso_oe_q   <= 1'b0;
            frame_end_q <= 1'b1;
          end else begin
            if (sck_rise_q) begin
              rx_shift_q <= rx_next;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                push_q      <= 1'b1;
                push_data_q <= rx_next;
                byte_done_q <= 1'b1;
              end
            end
            if (sck_fall_q) begin
              if (byte_done_q) begin
                tx_shift_q  <= tx_next;
                byte_done_q <= 1'b0;
              end else begin
                tx_shift_q <= {tx_shift_q[6:0], 1'b1};
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // A write in the same cycle as a load leaves the new byte pending.
      if (tx_load) reply_full_q <= 1'b0;
      if (sys_we) begin
        reply_q      <= sys_wdata;
        reply_full_q <= 1'b1;
      end
    end
  end

  // RX storage
  logic rx_pop, rx_drop;
  assign rx_pop = sys_rd & rx_valid;

`ifdef SPI_TARGET_FIFO_EN
  logic fifo_full, fifo_empty;

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .input_clk (input_clk),
    .reset     (reset),
    .push_i    (push_q),
    .din_i     (push_data_q),
    .pop_i     (rx_pop),
    .dout_o    (sys_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_drop  = push_q & fifo_full & ~rx_pop;
`else
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else if (push_q && (!rx_valid_q || rx_pop)) begin
      rx_data_q  <= push_data_q;
      rx_valid_q <= 1'b1;
    end else if (rx_pop) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign sys_rdata = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_drop   = push_q & rx_valid_q & ~rx_pop;
`endif

  logic overrun_q;
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset)        overrun_q <= 1'b0;
    else if (rx_drop) overrun_q <= 1'b1;
    else if (sys_clr) overrun_q <= 1'b0;
  end

  assign spi_miso     = tx_shift_q[7];
  assign spi_miso_oe  = miso_oe_q;
  assign rx_overrun   = overrun_q;
  assign tx_empty     = ~reply_full_q;
  assign frame_active = ~ss_q[1];
  assign irq          = rx_valid | frame_end_q;
endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;
  localparam int HALF = 8;
  localparam logic [7:0] IDLE = 8'hFF;
`ifdef SPI_TARGET_FIFO_EN
  localparam int CAP = 16;
`else
  localparam int CAP = 1;
`endif

  logic       input_clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sck = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic       sys_we = 1'b0, sys_rd = 1'b0, sys_clr = 1'b0;
  logic [7:0] sys_wdata = 8'h00;
  logic [7:0] sys_rdata;
  logic       rx_valid, rx_overrun, tx_empty, frame_active, irq;

  int n_cmp = 0;
  int n_err = 0;

  spi_target dut (
    .input_clk(input_clk), .reset(reset),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .sys_we(sys_we), .sys_wdata(sys_wdata), .sys_rd(sys_rd), .sys_clr(sys_clr),
    .sys_rdata(sys_rdata), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
    .tx_empty(tx_empty), .frame_active(frame_active), .irq(irq)
  );

  always #5 input_clk = ~input_clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge input_clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Host shifts out tx[7] down to tx[8-nb] and samples MISO at each rising edge.
  // With rd_end set, sys_rd is pulsed on the same clock edge that stores the
  // completed byte.
  task automatic spi_bits(input logic [7:0] tx, input int nb, input bit rd_end,
                          output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 7; i >= 8 - nb; i--) begin
      spi_mosi = tx[i];
      wclk(HALF);
      spi_sck = 1'b1;
      rx[i] = spi_miso;
      if (i == 0 && rd_end) begin
        wclk(4); sys_rd = 1'b1; wclk(1); sys_rd = 1'b0; wclk(HALF - 5);
      end else begin
        wclk(HALF);
      end
      spi_sck = 1'b0;
    end
    wclk(HALF);
  endtask

  task automatic ss_low();  spi_ss = 1'b0; wclk(8); endtask
  task automatic ss_high(); spi_ss = 1'b1; wclk(8); endtask
  task automatic cpu_write(input logic [7:0] b);
    sys_we = 1'b1; sys_wdata = b; wclk(1); sys_we = 1'b0;
  endtask
  task automatic cpu_pop(); sys_rd = 1'b1; wclk(1); sys_rd = 1'b0; endtask
  task automatic cpu_clr(); sys_clr = 1'b1; wclk(1); sys_clr = 1'b0; endtask

  typedef struct {
    logic [7:0] mosi;
    bit         load;
    logic [7:0] reply;
    logic [7:0] exp_miso;
  } vec_t;
  vec_t vt[4];

  logic [7:0] rx;
  logic [7:0] q[$];
  bit         ovr_m, pend_m;
  logic [7:0] reply_m, tx, exp;
  int         nb, npop;

  initial begin
    vt[0] = '{8'hA5, 1'b0, 8'h00, 8'hFF};
    vt[1] = '{8'h00, 1'b1, 8'h3C, 8'h3C};
    vt[2] = '{8'h81, 1'b1, 8'h7E, 8'h7E};
    vt[3] = '{8'h5A, 1'b0, 8'h00, 8'hFF};

    // reset values
    wclk(3);
    chk("rst_miso", spi_miso, 1); chk("rst_oe", spi_miso_oe, 0);
    chk("rst_rdata", sys_rdata, 0); chk("rst_rxv", rx_valid, 0);
    chk("rst_ovr", rx_overrun, 0); chk("rst_txe", tx_empty, 1);
    chk("rst_fa", frame_active, 0); chk("rst_irq", irq, 0);
    reset = 1'b0;
    wclk(4);

    // single-byte frames from the table
    foreach (vt[k]) begin
      if (vt[k].load) begin
        cpu_write(vt[k].reply);
        chk("tbl_txe_loaded", tx_empty, 0);
      end
      ss_low();
      chk("tbl_fa", frame_active, 1); chk("tbl_oe", spi_miso_oe, 1);
      chk("tbl_txe_after_ssfall", tx_empty, 1);
      spi_bits(vt[k].mosi, 8, 0, rx);
      ss_high();
      chk("tbl_host_rx", rx, vt[k].exp_miso);
      chk("tbl_rxv", rx_valid, 1); chk("tbl_rdata", sys_rdata, vt[k].mosi);
      chk("tbl_ovr", rx_overrun, 0); chk("tbl_oe_off", spi_miso_oe, 0);
      cpu_pop();
      chk("tbl_rxv_popped", rx_valid, 0);
    end
    cpu_clr();

    // three bytes, no reads
    ss_low();
    spi_bits(8'hA1, 8, 0, rx); spi_bits(8'hB2, 8, 0, rx); spi_bits(8'hC3, 8, 0, rx);
    ss_high();
`ifdef SPI_TARGET_FIFO_EN
    chk("burst_rd0", sys_rdata, 8'hA1); cpu_pop();
    chk("burst_rd1", sys_rdata, 8'hB2); cpu_pop();
    chk("burst_rd2", sys_rdata, 8'hC3); cpu_pop();
    chk("burst_ovr", rx_overrun, 0);
`else
    chk("burst_rd0", sys_rdata, 8'hA1); chk("burst_ovr", rx_overrun, 1);
    cpu_pop();
`endif
    chk("burst_empty", rx_valid, 0);
    cpu_clr();
    chk("burst_ovr_clr", rx_overrun, 0); chk("burst_irq_clr", irq, 0);

    // SS released after 5 bits
    ss_low();
    spi_bits(8'hF0, 5, 0, rx);
    ss_high();
    chk("part_rxv", rx_valid, 0); chk("part_irq", irq, 1); chk("part_oe", spi_miso_oe, 0);
    cpu_clr();
    chk("part_irq_clr", irq, 0);
    ss_low(); spi_bits(8'h81, 8, 0, rx); ss_high();
    chk("part_next_rdata", sys_rdata, 8'h81); chk("part_next_rxv", rx_valid, 1);
    chk("part_next_host", rx, 8'hFF);
    cpu_pop(); cpu_clr();

    // sys_rd in the same cycle as byte completion
    ss_low(); spi_bits(8'h11, 8, 0, rx); ss_high();
    chk("rdpush_first", sys_rdata, 8'h11);
    ss_low(); spi_bits(8'h22, 8, 1, rx); ss_high();
    chk("rdpush_rdata", sys_rdata, 8'h22); chk("rdpush_rxv", rx_valid, 1);
    chk("rdpush_ovr", rx_overrun, 0);
    cpu_pop();
    chk("rdpush_empty", rx_valid, 0);
    cpu_clr();

    // reset in the middle of a byte
    cpu_write(8'h77);
    ss_low(); spi_bits(8'hF0, 4, 0, rx);
    chk("mid_fa_before", frame_active, 1);
    reset = 1'b1;
    wclk(1);
    chk("mid_miso", spi_miso, 1); chk("mid_oe", spi_miso_oe, 0);
    chk("mid_rdata", sys_rdata, 0); chk("mid_rxv", rx_valid, 0);
    chk("mid_ovr", rx_overrun, 0); chk("mid_txe", tx_empty, 1);
    chk("mid_fa", frame_active, 0); chk("mid_irq", irq, 0);
    spi_ss = 1'b1; spi_sck = 1'b0;
    wclk(2); reset = 1'b0; wclk(4);
    ss_low(); spi_bits(8'h5A, 8, 0, rx); ss_high();
    chk("mid_after_rdata", sys_rdata, 8'h5A); chk("mid_after_host", rx, 8'hFF);
    cpu_pop(); cpu_clr();

    // randomized frames against a queue model
    q.delete(); ovr_m = 0; pend_m = 0; reply_m = 8'h00;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        reply_m = 8'($urandom);
        cpu_write(reply_m);
        pend_m = 1;
      end
      nb = $urandom_range(1, 3);
      ss_low();
      for (int k = 0; k < nb; k++) begin
        tx  = 8'($urandom);
        exp = (k == 0 && pend_m) ? reply_m : IDLE;
        spi_bits(tx, 8, 0, rx);
        chk("rnd_host_rx", rx, exp);
        if (q.size() < CAP) q.push_back(tx);
        else ovr_m = 1;
      end
      pend_m = 0;
      ss_high();
      chk("rnd_ovr", rx_overrun, ovr_m);
      chk("rnd_rxv", rx_valid, (q.size() > 0));
      npop = $urandom_range(0, q.size());
      for (int p = 0; p < npop; p++) begin
        chk("rnd_rdata", sys_rdata, q[0]);
        cpu_pop();
        void'(q.pop_front());
      end
      chk("rnd_rxv_after_pop", rx_valid, (q.size() > 0));
      if ($urandom_range(0, 3) == 0) begin
        cpu_clr();
        ovr_m = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
